seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Parametrised multi-cycle restoring divider producing both quotient and remainder.
- Supports a per-operation signed/unsigned mode, divide-by-zero detection, and a start/ready/valid handshake.
- Retires one quotient bit per clock, replacing the single-cycle unrolled unsigned divide on timing-critical datapaths.
- Sits beside the ALU and is launched by the execute-stage controller.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1): iteration counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launch request; accepted only when ready=1.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- ready  output  1  block is idle and can accept start.
- valid  output  1  one-cycle pulse; quotient, remainder and dbz are valid.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- dbz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-low on rst_n.
  - Reset values: state=IDLE, ready=1, valid=0, quotient=0, remainder=0, dbz=0, counter=0.
  - rst_n=0 mid-operation aborts the divide; no valid is emitted.
- States:
  - IDLE: ready=1. On start=1, latch operands and signed_op.
    - If divisor==0, go to DONE.
    - Otherwise go to CALC with counter=0.
  - CALC: ready=0, one iteration per clock.
    - Shift {partial_rem, work_dividend} left by 1.
    - Trial-subtract the divisor magnitude from partial_rem (WIDTH+1-bit arithmetic).
    - Borrow clear: keep the difference and set quotient bit=1.
    - Borrow set: restore and set quotient bit=0.
    - After WIDTH iterations, go to DONE.
  - DONE: ready=0, valid=1 for exactly this cycle; the next clock returns to IDLE.
- Signed handling (signed_op=1):
  - Operands are converted to magnitudes at latch time.
  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Quotient truncates toward zero.
  - MIN/-1 produces quotient=MIN (wraps), remainder=0, dbz=0.
- Divide by zero:
  - quotient = all ones.
  - remainder = dividend, unmodified.
  - dbz=1.
  - Applies in both signed and unsigned modes.
- Latency (start accepted at edge k):
  - Normal divide: valid high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 clocks start-to-valid.
  - Divide by zero: valid high in the cycle after edge k+1.
  - ready returns to 1 on the clock following valid.
  - There is no back-to-back issue in the valid cycle.
- Output hold and ignored inputs:
  - quotient, remainder and dbz hold their values from valid until the next result is written.
  - start while ready=0 is ignored; it is not queued.
  - Operand changes after acceptance have no effect.
- Width rules:
  - The internal partial remainder is WIDTH+1 bits, so the full unsigned range is correct, including a divisor with MSB set.
  - The quotient register is WIDTH bits.

Test Plan:
- Unsigned, WIDTH=32: start with 100/7 -> after 34 clocks, valid=1, quotient=14, remainder=2, dbz=0; ready=1 one clock later.
- Signed: -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Unsigned large divisor: 0xFFFFFFFF/0x80000000 -> quotient=1, remainder=0x7FFFFFFF. Repeat with signed_op=1 -> quotient=0, remainder=0xFFFFFFFF.
- Divide by zero: 1234/0, both modes -> valid 2 clocks after start, quotient=0xFFFFFFFF, remainder=1234, dbz=1.
- Signed overflow and busy start: 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. A second start pulsed mid-CALC is ignored; exactly one valid pulse appears.
- Reset mid-operation: drive rst_n=0 for one clock at iteration 10 -> ready=1, valid=0, quotient=0, remainder=0 next cycle, with no stray valid. A subsequent 9/3 -> quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed/unsigned per operation,
// divide-by-zero flagged, start/ready/valid handshake.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dmag;
  logic             neg_q, neg_r, dbz_l;
  logic [WIDTH+1:0] shifted, trial;
  logic             borrow;
  logic             accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign accept = (state == IDLE) && start;

  // One restoring step: shift in the next dividend bit, trial-subtract, borrow decides restore.
  always_comb begin
    shifted = {rem, work[WIDTH-1]};
    trial   = shifted - {2'b00, dmag};
    borrow  = trial[WIDTH+1];
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = (divisor == '0) ? FINISH : CALC;
      end
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = DONE;
      DONE: begin
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)              cnt <= '0;
      else if (state == CALC)  cnt <= cnt + 1'b1;
      // Sign fix-up and result write; outputs then hold until the next result.
      if (state == FINISH) begin
        quotient  <= dbz_l ? '1   : apply_sign(work, neg_q);
        remainder <= dbz_l ? work : apply_sign(rem[WIDTH-1:0], neg_r);
        dbz       <= dbz_l;
      end
    end
  end

  // Working registers carry no reset; they are always reloaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem   <= '0;
      dbz_l <= (divisor == '0);
      neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= signed_op && dividend[WIDTH-1];
      dmag  <= magnitude(divisor, signed_op);
      work  <= (divisor == '0) ? dividend : magnitude(dividend, signed_op);
    end else if (state == CALC) begin
      rem   <= borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
      work  <= {work[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: latency/arithmetic reference model compared every cycle,
// directed literal cases, and a randomized phase with busy starts and sporadic resets.
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready, valid, dbz;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .ready(ready), .valid(valid),
    .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference from plain integer division.
  function automatic void model_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r, output logic z);
    longint a, b;
    a = longint'($signed(dd));
    b = longint'($signed(dv));
    if (dv == '0) begin
      q = '1; r = dd; z = 1'b1;
    end else if (s) begin
      q = 32'(a / b); r = 32'(a % b); z = 1'b0;
    end else begin
      q = dd / dv; r = dd % dv; z = 1'b0;
    end
  endfunction

  // Handshake/latency reference: counts edges from acceptance to the result.
  bit           m_ready = 1'b1;
  bit           m_valid = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;
  logic         m_z = 1'b0, p_z;
  int           m_pulses = 0;
  int           d_pulses = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready = 1'b1; m_valid = 1'b0; m_cnt = 0;
      m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_ready && start) begin
      model_div(dividend, divisor, signed_op, p_q, p_r, p_z);
      m_cnt   = (divisor == '0) ? 1 : W + 1;
      m_ready = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1; m_q = p_q; m_r = p_r; m_z = p_z;
        m_pulses++;
      end
    end else if (m_valid) begin
      m_valid = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk1("ready", ready, m_ready);
      chk1("valid", valid, m_valid);
      chkw("quotient", quotient, m_q);
      chkw("remainder", remainder, m_r);
      chk1("dbz", dbz, m_z);
      if (valid) d_pulses++;
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (!(m_ready && !m_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk1("idle_wait", (w < 200), 1'b1);
  endtask

  // Directed operation with literal expectations; busy_at >= 0 pulses a second start mid-CALC.
  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int elat, input int busy_at);
    int n = 0;
    wait_idle();
    dividend = dd; divisor = dv; signed_op = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = ~s;
    while (!valid && n < 200) begin
      if (n == busy_at) begin
        dividend = 32'd5; divisor = 32'd1; signed_op = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chkw("lit_latency", W'(n), W'(elat));
    chkw("lit_quotient", quotient, eq);
    chkw("lit_remainder", remainder, er);
    chk1("lit_dbz", dbz, ez);
    @(posedge clk);
    @(negedge clk);
    chk1("lit_ready_after", ready, 1'b1);
    chk1("lit_valid_after", valid, 1'b0);
    chkw("lit_hold_quotient", quotient, eq);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_valid", valid, 1'b0);
    chkw("rst_quotient", quotient, 32'h0);
    chkw("rst_remainder", remainder, 32'h0);
    chk1("rst_dbz", dbz, 1'b0);
    rst_n = 1'b1;
    checking = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W + 1, -1);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, W + 1, -1);
    run_op(32'hFFFFFFFF, 32'h80000000, 1'b0, 32'd1, 32'h7FFFFFFF, 1'b0, W + 1, -1);
    run_op(32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0, 32'hFFFFFFFF, 1'b0, W + 1, -1);
    run_op(32'd1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1, -1);
    run_op(32'd1234, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd1234, 1'b1, 1, -1);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, W + 1, 10);
    repeat (40) @(negedge clk);
    chkw("busy_pulse_count", W'(d_pulses), W'(m_pulses));

    // Abort mid-divide with a one-cycle reset.
    wait_idle();
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk1("abort_ready", ready, 1'b1);
    chk1("abort_valid", valid, 1'b0);
    chkw("abort_quotient", quotient, 32'h0);
    chkw("abort_remainder", remainder, 32'h0);
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, W + 1, -1);

    repeat (9000) begin
      @(negedge clk);
      start     = ($urandom_range(0, 2) == 0);
      signed_op = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1:       divisor = '1;
        2:       divisor = 32'd1;
        3:       divisor = $urandom_range(1, 15);
        default: divisor = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       dividend = 32'h80000000;
        1:       dividend = $urandom_range(0, 100);
        default: dividend = $urandom;
      endcase
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    chkw("total_pulse_count", W'(d_pulses), W'(m_pulses));
    checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
